// File: rtl/fft_peak_track_pkg.sv
// Shared sizes, input FSM encoding and bin field slices for fft_peak_track.
// Optional feature macro: PEAK_INDEX_EN (adds per-band peak bin index outputs).
`ifndef FFT_PEAK_TRACK_PKG_SV
`define FFT_PEAK_TRACK_PKG_SV
package fft_peak_track_pkg;
  localparam int DW        = 12;
  localparam int VLEN      = 16;
  localparam int VLEN_LOG2 = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } in_state_e;

  typedef logic [DW-1:0]        mag_t;
  typedef logic [VLEN_LOG2-1:0] bin_t;

  localparam bin_t LAST_BIN = bin_t'(VLEN - 1);
endpackage

// Real part sits in the upper half of a bin word, imaginary in the lower half.
`define FPT_BIN_RE(x) x[2*fft_peak_track_pkg::DW-1 -: fft_peak_track_pkg::DW]
`define FPT_BIN_IM(x) x[fft_peak_track_pkg::DW-1 -: fft_peak_track_pkg::DW]
`endif

// File: rtl/fft_peak_track_if.sv
// Bin stream in / peak report out for fft_peak_track.
// Optional feature macro: PEAK_INDEX_EN (adds idx730/idx850).
interface fft_peak_track_if;
  import fft_peak_track_pkg::*;

  logic [2*DW-1:0] in_x;
  logic            in_nd;
  logic            in_sof;
  logic            in_ovf;
  logic [DW-1:0]   max730;
  logic [DW-1:0]   max850;
  logic            out_valid;
  logic            out_ovf;
  logic            frame_err;
`ifdef PEAK_INDEX_EN
  logic [VLEN_LOG2-1:0] idx730;
  logic [VLEN_LOG2-1:0] idx850;

  modport master (
    output in_x, in_nd, in_sof, in_ovf,
    input  max730, max850, out_valid, out_ovf, frame_err, idx730, idx850
  );
  modport slave (
    input  in_x, in_nd, in_sof, in_ovf,
    output max730, max850, out_valid, out_ovf, frame_err, idx730, idx850
  );
`else
  modport master (
    output in_x, in_nd, in_sof, in_ovf,
    input  max730, max850, out_valid, out_ovf, frame_err
  );
  modport slave (
    input  in_x, in_nd, in_sof, in_ovf,
    output max730, max850, out_valid, out_ovf, frame_err
  );
`endif
endinterface

// File: rtl/peak_band_track.sv
// One band peak tracker: restart on sof, keep first strictly-greater in-band magnitude.
// Optional feature macro: PEAK_INDEX_EN (also tracks the bin of the peak).
module peak_band_track
  import fft_peak_track_pkg::*;
#(
  parameter int LO = 1,
  parameter int HI = 3
) (
  input  logic clk,
  input  logic vld,
  input  logic sof,
  input  bin_t bin,
  input  mag_t mag,
`ifdef PEAK_INDEX_EN
  output bin_t idx_nxt,
`endif
  output mag_t peak_nxt
);
  localparam bin_t LO_B = bin_t'(LO);
  localparam bin_t HI_B = bin_t'(HI);

  if (!(LO >= 0 && LO <= HI && HI < VLEN)) begin : g_bad_band
    $error("peak_band_track: band bounds must satisfy 0 <= LO <= HI < VLEN");
  end

  mag_t cur_q, cur_d;
  bin_t idx_q, idx_d;
  logic in_band;

  always_comb begin
    in_band = (bin >= LO_B) && (bin <= HI_B);
    cur_d   = cur_q;
    idx_d   = idx_q;
    if (vld) begin
      if (sof) begin
        cur_d = '0;
        idx_d = '0;
      end
      // Strict compare so the earliest bin wins a tie.
      if (in_band && (mag > cur_d)) begin
        cur_d = mag;
        idx_d = bin;
      end
    end
  end

  // S3 boundary: tracker state is data-only and restarts on every sof.
  always_ff @(posedge clk) begin
    cur_q <= cur_d;
    idx_q <= idx_d;
  end

  assign peak_nxt = cur_d;
`ifdef PEAK_INDEX_EN
  assign idx_nxt  = idx_d;
`endif
endmodule

// File: rtl/fft_peak_track.sv
// Per-frame band peak tracker behind the FFT: |re|/|im| -> approx magnitude -> two band peaks.
// Optional feature macro: PEAK_INDEX_EN (publishes idx730/idx850 with the peaks).
module fft_peak_track
  import fft_peak_track_pkg::*;
#(
  parameter int A_LO = 1,
  parameter int A_HI = 3,
  parameter int B_LO = 4,
  parameter int B_HI = 7
) (
  input logic             clk,
  input logic             rst,
  fft_peak_track_if.slave bus
);

  function automatic mag_t abs_mag(input logic signed [DW-1:0] x);
    mag_t ux;
    ux = mag_t'(x);
    // -2^(DW-1) maps onto 2^(DW-1), which still fits unsigned DW bits.
    return x[DW-1] ? (~ux + 1'b1) : ux;
  endfunction

  function automatic mag_t approx_mag(input mag_t a, input mag_t b);
    mag_t hi, lo;
    if (a >= b) begin
      hi = a;
      lo = b;
    end else begin
      hi = b;
      lo = a;
    end
    return hi + (lo >> 1);
  endfunction

  // Input FSM: frame alignment and bin numbering.
  in_state_e state_q;
  bin_t      cnt_q;
  logic      frame_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (bus.in_nd) begin
        case (state_q)
          ST_IDLE: begin
            if (bus.in_sof) begin
              state_q <= ST_ACC;
              cnt_q   <= bin_t'(1);
            end
          end
          ST_ACC: begin
            if (bus.in_sof) begin
              frame_err_q <= 1'b1;
              cnt_q       <= bin_t'(1);
            end else begin
              cnt_q <= cnt_q + 1'b1;
              if (cnt_q == LAST_BIN) state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  logic acc_c, last_c;
  bin_t bin_c;

  always_comb begin
    acc_c  = bus.in_nd && (bus.in_sof || (state_q == ST_ACC));
    bin_c  = bus.in_sof ? '0 : cnt_q;
    last_c = !bus.in_sof && (cnt_q == LAST_BIN);
  end

  // S1 boundary: component magnitudes plus tags.
  logic vld_p1_q, vld_p1_d;
  mag_t a_p1_q, a_p1_d, b_p1_q, b_p1_d;
  bin_t bin_p1_q, bin_p1_d;
  logic sof_p1_q, sof_p1_d, last_p1_q, last_p1_d, ovf_p1_q, ovf_p1_d;

  always_comb begin
    vld_p1_d  = acc_c;
    a_p1_d    = abs_mag(`FPT_BIN_RE(bus.in_x));
    b_p1_d    = abs_mag(`FPT_BIN_IM(bus.in_x));
    bin_p1_d  = bin_c;
    sof_p1_d  = bus.in_sof;
    last_p1_d = last_c;
    ovf_p1_d  = bus.in_ovf;
  end

  // S2 boundary: approximate magnitude plus tags.
  logic vld_p2_q, vld_p2_d;
  mag_t mag_p2_q, mag_p2_d;
  bin_t bin_p2_q, bin_p2_d;
  logic sof_p2_q, sof_p2_d, last_p2_q, last_p2_d, ovf_p2_q, ovf_p2_d;

  always_comb begin
    vld_p2_d  = vld_p1_q;
    mag_p2_d  = approx_mag(a_p1_q, b_p1_q);
    bin_p2_d  = bin_p1_q;
    sof_p2_d  = sof_p1_q;
    last_p2_d = last_p1_q;
    ovf_p2_d  = ovf_p1_q;
  end

  always_ff @(posedge clk) begin
    a_p1_q    <= a_p1_d;
    b_p1_q    <= b_p1_d;
    bin_p1_q  <= bin_p1_d;
    sof_p1_q  <= sof_p1_d;
    last_p1_q <= last_p1_d;
    ovf_p1_q  <= ovf_p1_d;
    mag_p2_q  <= mag_p2_d;
    bin_p2_q  <= bin_p2_d;
    sof_p2_q  <= sof_p2_d;
    last_p2_q <= last_p2_d;
    ovf_p2_q  <= ovf_p2_d;
  end

  // S3 boundary: band trackers, then publish from their next-state values.
  mag_t peak_a_nxt, peak_b_nxt;
`ifdef PEAK_INDEX_EN
  bin_t idx_a_nxt, idx_b_nxt;
`endif

  peak_band_track #(.LO(A_LO), .HI(A_HI)) u_band_a (
    .clk      (clk),
    .vld      (vld_p2_q),
    .sof      (sof_p2_q),
    .bin      (bin_p2_q),
    .mag      (mag_p2_q),
`ifdef PEAK_INDEX_EN
    .idx_nxt  (idx_a_nxt),
`endif
    .peak_nxt (peak_a_nxt)
  );

  peak_band_track #(.LO(B_LO), .HI(B_HI)) u_band_b (
    .clk      (clk),
    .vld      (vld_p2_q),
    .sof      (sof_p2_q),
    .bin      (bin_p2_q),
    .mag      (mag_p2_q),
`ifdef PEAK_INDEX_EN
    .idx_nxt  (idx_b_nxt),
`endif
    .peak_nxt (peak_b_nxt)
  );

  logic pub_c;
  logic ovf_acc_q, ovf_acc_d;
  logic out_valid_q, out_valid_d, out_ovf_q, out_ovf_d;
  mag_t max730_q, max730_d, max850_q, max850_d;
`ifdef PEAK_INDEX_EN
  bin_t idx730_q, idx730_d, idx850_q, idx850_d;
`endif

  always_comb begin
    pub_c     = vld_p2_q && last_p2_q;
    ovf_acc_d = ovf_acc_q;
    if (vld_p2_q) ovf_acc_d = (sof_p2_q ? 1'b0 : ovf_acc_q) | ovf_p2_q;
    out_valid_d = pub_c;
    max730_d    = pub_c ? peak_a_nxt : max730_q;
    max850_d    = pub_c ? peak_b_nxt : max850_q;
    out_ovf_d   = pub_c ? ovf_acc_d  : out_ovf_q;
`ifdef PEAK_INDEX_EN
    idx730_d    = pub_c ? idx_a_nxt  : idx730_q;
    idx850_d    = pub_c ? idx_b_nxt  : idx850_q;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      ovf_acc_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_ovf_q   <= 1'b0;
      max730_q    <= '0;
      max850_q    <= '0;
`ifdef PEAK_INDEX_EN
      idx730_q    <= '0;
      idx850_q    <= '0;
`endif
    end else begin
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      ovf_acc_q   <= ovf_acc_d;
      out_valid_q <= out_valid_d;
      out_ovf_q   <= out_ovf_d;
      max730_q    <= max730_d;
      max850_q    <= max850_d;
`ifdef PEAK_INDEX_EN
      idx730_q    <= idx730_d;
      idx850_q    <= idx850_d;
`endif
    end
  end

  assign bus.max730    = max730_q;
  assign bus.max850    = max850_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.frame_err = frame_err_q;
`ifdef PEAK_INDEX_EN
  assign bus.idx730    = idx730_q;
  assign bus.idx850    = idx850_q;
`endif
endmodule
